// File: rtl/a_buff.sv
// Activation operand buffer: one register-file bank per PE column, shared address/enable,
// per-bank write strobe, registered read data.
module a_buff #(
    parameter int unsigned DATA_WIDTH      = 8,
    parameter int unsigned MEM_DEPTH       = 8,
    parameter int unsigned ADDR_WIDTH      = 3,
    parameter int unsigned NUM_MACS        = 2,
    parameter int unsigned NUM_PEs_PER_ROW = 4,
    parameter int unsigned NUM_ROWS        = 4
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic [NUM_PEs_PER_ROW*NUM_MACS*DATA_WIDTH-1:0] in,
    input  logic [ADDR_WIDTH-1:0]                         addr,
    input  logic                                          en,
    input  logic [NUM_PEs_PER_ROW-1:0]                    wr,
    output logic [NUM_PEs_PER_ROW*NUM_MACS*DATA_WIDTH-1:0] out
);

    // Width of one bank word (all operands feeding one PE column).
    localparam int unsigned W = NUM_MACS * DATA_WIDTH;

    // One extra bit so the depth itself is representable for the range compare.
    localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH + 1)'(MEM_DEPTH);

    // Elaboration guard on parameter sanity; NUM_ROWS is otherwise informational.
    if (NUM_ROWS < 1 || (2 ** ADDR_WIDTH) < MEM_DEPTH) begin : g_param_check
        $error("a_buff: illegal parameters (NUM_ROWS < 1 or address too narrow for MEM_DEPTH)");
    end

    logic addr_ok;

    // Addresses beyond the last word drop writes and read back as zero.
    assign addr_ok = ({1'b0, addr} < DEPTH_LIM);

    for (genvar i = 0; i < NUM_PEs_PER_ROW; i++) begin : g_bank
        logic [W-1:0] mem [MEM_DEPTH];
        logic [W-1:0] rd_q;
        logic [W-1:0] wdata;

        assign wdata = in[i*W +: W];

        // Bank storage: synchronous write, cleared by reset.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                for (int unsigned j = 0; j < MEM_DEPTH; j++) begin
                    mem[j] <= '0;
                end
            end else if (en && wr[i] && addr_ok) begin
                mem[addr] <= wdata;
            end
        end

        // Registered read; a bank being written keeps its previous output (no write-through).
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                rd_q <= '0;
            end else if (en && !wr[i]) begin
                rd_q <= addr_ok ? mem[addr] : '0;
            end
        end

        assign out[i*W +: W] = rd_q;
    end

endmodule

// File: tb/tb_a_buff.sv
// Scoreboard bench for a_buff: a depth-8 instance and a depth-6 instance share stimulus.
module tb_a_buff;

    logic        clk;
    logic        rst;
    logic [63:0] din;
    logic [2:0]  addr;
    logic        en;
    logic [3:0]  wr;
    logic [63:0] dout8;
    logic [63:0] dout6;

    int npass;
    int ntot;
    int cyc;

    typedef struct {
        int          due;
        bit          sel6;
        logic [63:0] exp;
        string       name;
    } exp_t;

    exp_t q[$];

    a_buff #(
        .DATA_WIDTH(8), .MEM_DEPTH(8), .ADDR_WIDTH(3),
        .NUM_MACS(2), .NUM_PEs_PER_ROW(4), .NUM_ROWS(4)
    ) dut (
        .clk(clk), .rst(rst), .in(din), .addr(addr), .en(en), .wr(wr), .out(dout8)
    );

    a_buff #(
        .DATA_WIDTH(8), .MEM_DEPTH(6), .ADDR_WIDTH(3),
        .NUM_MACS(2), .NUM_PEs_PER_ROW(4), .NUM_ROWS(4)
    ) dut6 (
        .clk(clk), .rst(rst), .in(din), .addr(addr), .en(en), .wr(wr), .out(dout6)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        ntot++;
        if (act === exp) begin
            npass++;
        end else begin
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: after each rising edge, pop and compare every entry due this cycle.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            while (q.size() > 0 && q[0].due <= cyc) begin
                exp_t e;
                e = q.pop_front();
                if (e.due < cyc) begin
                    ntot++;
                    $display("FAIL %s: stale entry due %0d at cycle %0d", e.name, e.due, cyc);
                end else begin
                    chk(e.name, e.sel6 ? dout6 : dout8, e.exp);
                end
            end
        end
    end

    // Drive one cycle of stimulus and queue the expected post-edge outputs.
    task automatic step(input bit e, input logic [3:0] w, input logic [2:0] a,
                        input logic [63:0] d, input bit c8, input logic [63:0] e8,
                        input bit c6, input logic [63:0] e6, input string nm);
        exp_t x;
        @(negedge clk);
        en   = e;
        wr   = w;
        addr = a;
        din  = d;
        if (c8) begin
            x.due = cyc + 1; x.sel6 = 1'b0; x.exp = e8; x.name = {nm, "/d8"};
            q.push_back(x);
        end
        if (c6) begin
            x.due = cyc + 1; x.sel6 = 1'b1; x.exp = e6; x.name = {nm, "/d6"};
            q.push_back(x);
        end
    endtask

    localparam logic [63:0] D0  = 64'h0102030405060708;
    localparam logic [63:0] D1  = 64'h100F0E0D0C0B0A09;
    localparam logic [63:0] D2  = 64'hA1A2A3A4A5A6A7A8;
    localparam logic [63:0] D7  = 64'hDEADBEEFCAFEF00D;
    localparam logic [63:0] ONE = 64'hFFFF_FFFF_FFFF_FFFF;

    initial begin
        npass = 0;
        ntot  = 0;
        cyc   = 0;
        rst   = 1'b1;
        en    = 1'b0;
        wr    = 4'h0;
        addr  = 3'd0;
        din   = 64'h0;
        #1 rst = 1'b0;
        #1;
        chk("por_out", dout8, 64'h0);
        chk("por_out6", dout6, 64'h0);
        @(negedge clk);
        rst = 1'b1;

        // Full writes, then reads
        step(1, 4'hF, 3'd0, D0, 1, 64'h0, 0, 0, "wr_a0_hold");
        step(1, 4'hF, 3'd1, D1, 1, 64'h0, 0, 0, "wr_a1_hold");
        step(1, 4'h0, 3'd0, 64'h0, 1, D0, 1, D0, "rd_a0");
        step(1, 4'h0, 3'd1, 64'h0, 1, D1, 1, D1, "rd_a1");
        // Disabled: outputs and memory frozen regardless of wr
        step(0, 4'hA, 3'd0, ONE, 1, D1, 0, 0, "dis_hold1");
        step(0, 4'h0, 3'd3, ONE, 1, D1, 0, 0, "dis_hold2");
        step(1, 4'h0, 3'd0, 64'h0, 1, D0, 0, 0, "rd_a0_after_dis");
        // Partial write: banks 0,2 hold, banks 1,3 read addr 0
        step(1, 4'h0, 3'd1, 64'h0, 1, D1, 0, 0, "rd_a1_pre");
        step(1, 4'h5, 3'd0, ONE, 1, 64'h01020E0D05060A09, 0, 0, "partial_mixed");
        step(1, 4'h0, 3'd0, 64'h0, 1, 64'h0102FFFF0506FFFF, 1, 64'h0102FFFF0506FFFF, "rd_partial");
        // Write while reading: output holds during write
        step(1, 4'h0, 3'd1, 64'h0, 1, D1, 0, 0, "rd_a1_again");
        step(1, 4'hF, 3'd2, D2, 1, D1, 0, 0, "wr_a2_hold");
        step(1, 4'h0, 3'd2, 64'h0, 1, D2, 1, D2, "rd_a2");
        // Depth boundary
        step(1, 4'hF, 3'd7, D7, 1, D2, 1, D2, "wr_a7_hold");
        step(1, 4'h0, 3'd7, 64'h0, 1, D7, 1, 64'h0, "rd_a7");
        step(1, 4'h0, 3'd1, 64'h0, 1, D1, 1, D1, "rd_a1_post7");
        step(1, 4'h0, 3'd0, 64'h0, 1, 64'h0102FFFF0506FFFF, 1, 64'h0102FFFF0506FFFF,
             "rd_a0_post7");
        step(1, 4'h0, 3'd6, 64'h0, 1, 64'h0, 1, 64'h0, "rd_a6");
        step(1, 4'h0, 3'd2, 64'h0, 1, D2, 1, D2, "rd_a2_final");

        // Mid-simulation asynchronous reset with random inputs
        @(negedge clk);
        en   = 1'b1;
        wr   = 4'($urandom_range(0, 15));
        addr = 3'($urandom_range(0, 7));
        din  = {$urandom, $urandom};
        #2 rst = 1'b0;
        #1;
        chk("rst_async", dout8, 64'h0);
        chk("rst_async6", dout6, 64'h0);
        @(posedge clk);
        #1;
        chk("rst_held", dout8, 64'h0);
        chk("rst_held6", dout6, 64'h0);
        @(negedge clk);
        en  = 1'b0;
        rst = 1'b1;
        for (int a = 0; a < 8; a++) begin
            step(1, 4'h0, 3'(a), 64'h0, 1, 64'h0, 1, 64'h0, "rd_after_rst");
        end

        repeat (3) @(posedge clk);
        #2;
        ntot++;
        if (q.size() != 0) begin
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
        end else begin
            npass++;
        end
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
